// File: rtl/clkdll_seq_pkg.sv
// Shared encodings and widths for the CLKDLL reset/lock sequencer.
package clkdll_seq_pkg;

   localparam int unsigned StateW         = 3;
   localparam int unsigned RetryW         = 4;
   localparam int unsigned LossW          = 8;
   localparam int unsigned LockTimeoutDef = 65535;
   localparam logic [LossW-1:0] LossSat   = 8'd255;

   typedef enum logic [StateW-1:0] {
      StIdle     = 3'd0,
      StHoldRst  = 3'd1,
      StWaitLock = 3'd2,
      StFilter   = 3'd3,
      StLocked   = 3'd4,
      StFailed   = 3'd5
   } state_e;

   // Bits needed to hold any count from 0 up to max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clkdll_lock_seq_if.sv
// Control/status bundle between the sequencer and its CLKDLL / downstream logic.
interface clkdll_lock_seq_if;
   import clkdll_seq_pkg::*;

   logic              en;
   logic              dll_locked;
   logic              dll_rst;
   logic              ready;
   logic              fail;
   logic [RetryW-1:0] retry_cnt;
   logic [LossW-1:0]  loss_cnt;
   logic [StateW-1:0] state;

   modport master (
      input  en, dll_locked,
      output dll_rst, ready, fail, retry_cnt, loss_cnt, state
   );

   modport slave (
      output en, dll_locked,
      input  dll_rst, ready, fail, retry_cnt, loss_cnt, state
   );

endinterface

// File: rtl/clkdll_sync.sv
// Multi-flop synchronizer for a level signal from another clock domain; resets to 0.
module clkdll_sync #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SyncStages-1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= '0;
      end else begin
         ff_q[0] <= d;
         for (int i = 1; i < SyncStages; i++) begin
            ff_q[i] <= ff_q[i-1];
         end
      end
   end

   assign q = ff_q[SyncStages-1];

endmodule

// File: rtl/clkdll_lock_seq.sv
// Reset/lock sequencer for one CLKDLL: reset pulse, lock wait with timeout and retries,
// glitch-filtered lock/loss detection, registered READY/FAIL status.
module clkdll_lock_seq
   import clkdll_seq_pkg::*;
#(
   parameter int unsigned RstCycles   = 3,
   parameter int unsigned LockTimeout = LockTimeoutDef,
   parameter int unsigned LockFilter  = 4,
   parameter int unsigned MaxRetry    = 7,
   parameter int unsigned SyncStages  = 2
) (
   input logic                clk,
   input logic                rst_n,
   clkdll_lock_seq_if.master  bus
);

   localparam int unsigned TmoW  = cnt_width(LockTimeout);
   localparam int unsigned FiltW = cnt_width(LockFilter);
   localparam int unsigned HoldW = cnt_width(RstCycles);

   state_e            state_q, state_d;
   logic [TmoW-1:0]   tmo_q, tmo_d, tmo_inc;
   logic [FiltW-1:0]  filt_q, filt_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [LossW-1:0]  loss_q, loss_d;
   logic              dll_rst_q, dll_rst_d;
   logic              ready_q, ready_d;
   logic              fail_q, fail_d;
   logic              lk, timeout, expire;

   clkdll_sync #(
      .SyncStages (SyncStages)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.dll_locked),
      .q     (lk)
   );

   // >= so a timer that ran past the limit while filtering still expires later.
   assign timeout = (tmo_q >= TmoW'(LockTimeout - 1));
   assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + 1'b1;

   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      filt_d  = '0;
      hold_d  = '0;
      retry_d = retry_q;
      loss_d  = loss_q;
      expire  = 1'b0;

      if (!bus.en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StHoldRst;
               retry_d = '0;
            end
            StHoldRst: begin
               hold_d = hold_q + 1'b1;
               if (hold_q == HoldW'(RstCycles - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
               tmo_d = tmo_inc;
               if (lk) begin
                  state_d = StFilter;
                  filt_d  = FiltW'(1);
               end else if (timeout) begin
                  expire = 1'b1;
               end
            end
            StFilter: begin
               tmo_d = tmo_inc;
               if (lk) begin
                  filt_d = filt_q + 1'b1;
                  if (filt_d == FiltW'(LockFilter)) begin
                     state_d = StLocked;
                     filt_d  = '0;
                  end
               end else if (timeout) begin
                  expire = 1'b1;
               end else begin
                  state_d = StWaitLock;
               end
            end
            StLocked: begin
               // filt counts consecutive unlocked cycles here.
               if (!lk) begin
                  filt_d = filt_q + 1'b1;
                  if (filt_d == FiltW'(LockFilter)) begin
                     state_d = StHoldRst;
                     filt_d  = '0;
                     if (loss_q != LossSat) loss_d = loss_q + 1'b1;
                  end
               end
            end
            StFailed: begin
               state_d = StFailed;
            end
            default: begin
               state_d = StIdle;
            end
         endcase

         if (expire) begin
            tmo_d = '0;
            if (retry_q == RetryW'(MaxRetry)) begin
               state_d = StFailed;
            end else begin
               retry_d = retry_q + 1'b1;
               state_d = StHoldRst;
            end
         end
         if (state_d == StLocked) retry_d = '0;
      end

      dll_rst_d = (state_d inside {StIdle, StHoldRst, StFailed});
      ready_d   = (state_d == StLocked);
      fail_d    = (state_d == StFailed);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         tmo_q     <= '0;
         filt_q    <= '0;
         hold_q    <= '0;
         retry_q   <= '0;
         loss_q    <= '0;
         dll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         filt_q    <= filt_d;
         hold_q    <= hold_d;
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         dll_rst_q <= dll_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign bus.dll_rst   = dll_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fail      = fail_q;
   assign bus.retry_cnt = retry_q;
   assign bus.loss_cnt  = loss_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_clkdll_lock_seq.sv
// Self-checking bench: timestamp-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized LOCKED/EN phase.
module tb_clkdll_lock_seq;

   localparam int RstC = 3;
   localparam int Lt   = 20;
   localparam int Lf   = 4;
   localparam int Mr   = 2;
   localparam int Ss   = 2;

   localparam int EncIdle = 0;
   localparam int EncHold = 1;
   localparam int EncWait = 2;
   localparam int EncFilt = 3;
   localparam int EncLock = 4;
   localparam int EncFail = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   clkdll_lock_seq_if bus ();

   clkdll_lock_seq #(
      .RstCycles   (RstC),
      .LockTimeout (Lt),
      .LockFilter  (Lf),
      .MaxRetry    (Mr),
      .SyncStages  (Ss)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference model: tracks event timestamps and run lengths of the synchronized lock.
   int m_st = EncIdle, m_retry = 0, m_loss = 0;
   int t_hold = 0, t_att = 0, t_lock = 0;
   int ones_run = 0, zeros_run = 0, cyc = 0;
   bit m_lk;
   bit lk_hist[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = EncIdle; m_retry = 0; m_loss = 0;
         ones_run = 0; zeros_run = 0; cyc = 0;
         lk_hist.delete();
         for (int i = 0; i < Ss; i++) lk_hist.push_back(1'b0);
      end else begin
         cyc++;
         m_lk = lk_hist.pop_front();
         lk_hist.push_back(bus.dll_locked);
         if (m_lk) begin ones_run++; zeros_run = 0; end
         else begin zeros_run++; ones_run = 0; end
         if (!bus.en) begin
            m_st = EncIdle;
         end else begin
            case (m_st)
               EncIdle: begin m_st = EncHold; m_retry = 0; t_hold = cyc + 1; end
               EncHold: if (cyc - t_hold == RstC - 1) begin m_st = EncWait; t_att = cyc + 1; end
               EncWait, EncFilt: begin
                  if (m_lk && min2(ones_run, cyc - t_att + 1) >= Lf) begin
                     m_st = EncLock; t_lock = cyc + 1; m_retry = 0;
                  end else if (m_lk) begin
                     m_st = EncFilt;
                  end else if (cyc - t_att >= Lt - 1) begin
                     if (m_retry == Mr) m_st = EncFail;
                     else begin m_retry++; m_st = EncHold; t_hold = cyc + 1; end
                  end else begin
                     m_st = EncWait;
                  end
               end
               EncLock: begin
                  if (!m_lk && min2(zeros_run, cyc - t_lock + 1) >= Lf) begin
                     m_st = EncHold; t_hold = cyc + 1;
                     if (m_loss < 255) m_loss++;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_state", int'(bus.state), m_st);
      check("cyc_dll_rst", int'(bus.dll_rst),
            (m_st == EncIdle || m_st == EncHold || m_st == EncFail) ? 1 : 0);
      check("cyc_ready", int'(bus.ready), (m_st == EncLock) ? 1 : 0);
      check("cyc_fail", int'(bus.fail), (m_st == EncFail) ? 1 : 0);
      check("cyc_retry", int'(bus.retry_cnt), m_retry);
      check("cyc_loss", int'(bus.loss_cnt), m_loss);
   end

   // Counts HOLD_RST cycles until dll_rst falls; called on a falling clock edge.
   task automatic count_hold(output int n);
      int k;
      n = 0;
      k = 0;
      while (bus.dll_rst !== 1'b0 && k < 50) begin
         if (bus.state == 3'd1) n++;
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int n, k, low, hrun;
      int hl[$], hr[$], gl[$];
      bit saw_filt, saw_back, any_ready;

      bus.en = 1'b0;
      bus.dll_locked = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dll_rst", int'(bus.dll_rst), 1);
      check("rst_state", int'(bus.state), 0);
      check("rst_ready", int'(bus.ready), 0);
      rst_n = 1'b1;

      // Normal lock
      @(negedge clk);
      bus.en = 1'b1;
      count_hold(n);
      check("lock_hold_len", n, 3);
      repeat (5) @(negedge clk);
      bus.dll_locked = 1'b1;
      k = 0;
      while (bus.ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      check("lock_ready_latency", k, 6);
      check("lock_retry", int'(bus.retry_cnt), 0);

      // Short dropout in LOCKED
      bus.dll_locked = 1'b0;
      repeat (3) @(negedge clk);
      bus.dll_locked = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_ready", int'(bus.ready), 1);
      check("glitch_loss", int'(bus.loss_cnt), 0);

      // Sustained loss, then re-lock
      bus.dll_locked = 1'b0;
      k = 0;
      while (bus.ready !== 1'b0 && k < 20) begin @(negedge clk); k++; end
      check("loss_ready_latency", k, 6);
      check("loss_cnt_after", int'(bus.loss_cnt), 1);
      count_hold(n);
      check("loss_hold_len", n, 3);
      bus.dll_locked = 1'b1;
      k = 0;
      while (bus.ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      check("relock_ready", int'(bus.ready), 1);

      // Restart, then a 1-cycle dropout while filtering
      bus.en = 1'b0;
      bus.dll_locked = 1'b0;
      @(negedge clk);
      check("abort_lock_state", int'(bus.state), 0);
      check("abort_lock_ready", int'(bus.ready), 0);
      bus.en = 1'b1;
      count_hold(n);
      bus.dll_locked = 1'b1;
      repeat (2) @(negedge clk);
      bus.dll_locked = 1'b0;
      saw_filt = 0; saw_back = 0; any_ready = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.state == 3'd3) saw_filt = 1;
         if (saw_filt && bus.state == 3'd2) saw_back = 1;
         if (bus.ready) any_ready = 1;
      end
      check("filt_entered", int'(saw_filt), 1);
      check("filt_rejected", int'(saw_back), 1);
      check("filt_no_ready", int'(any_ready), 0);

      // EN abort in WAIT_LOCK
      bus.en = 1'b0;
      @(negedge clk);
      check("abort_wait_state", int'(bus.state), 0);
      check("abort_wait_dll_rst", int'(bus.dll_rst), 1);

      // Timeout and retry exhaustion
      bus.en = 1'b1;
      low = 0; hrun = 0;
      for (int i = 0; i < 200 && bus.fail !== 1'b1; i++) begin
         @(negedge clk);
         if (bus.state == 3'd1) begin
            if (hrun == 0) hr.push_back(int'(bus.retry_cnt));
            hrun++;
         end else if (hrun > 0) begin
            hl.push_back(hrun); hrun = 0;
         end
         if (bus.dll_rst == 1'b0) low++;
         else if (low > 0) begin gl.push_back(low); low = 0; end
      end
      check("exh_pulses", hl.size(), 3);
      check("exh_gaps", gl.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("exh_hold_len", (i < hl.size()) ? hl[i] : -1, 3);
         check("exh_gap_len", (i < gl.size()) ? gl[i] : -1, 20);
         check("exh_retry_step", (i < hr.size()) ? hr[i] : -1, i);
      end
      check("exh_fail", int'(bus.fail), 1);
      check("exh_dll_rst", int'(bus.dll_rst), 1);
      check("exh_state", int'(bus.state), 5);

      // EN abort in FAILED, fresh restart
      bus.en = 1'b0;
      @(negedge clk);
      check("abort_fail_state", int'(bus.state), 0);
      check("abort_fail_fail", int'(bus.fail), 0);
      check("abort_fail_loss_kept", int'(bus.loss_cnt), 1);
      bus.en = 1'b1;
      @(negedge clk);
      check("restart_state", int'(bus.state), 1);
      check("restart_retry", int'(bus.retry_cnt), 0);

      // Asynchronous reset between edges during HOLD_RST
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dll_rst", int'(bus.dll_rst), 1);
      check("arst_state", int'(bus.state), 0);
      check("arst_loss", int'(bus.loss_cnt), 0);
      check("arst_ready", int'(bus.ready), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized lock activity with occasional EN drops
      for (int seg = 0; seg < 300; seg++) begin
         int len;
         len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
         bus.dll_locked = ~bus.dll_locked;
         for (int i = 0; i < len; i++) begin
            bus.en = ($urandom_range(0, 249) != 0);
            @(negedge clk);
         end
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
